// File: rtl/srl_fifo_ctrl_pkg.sv
// Shared types and elaboration helpers for the SRL FIFO controller.
// Optional occupancy outputs are enabled with the SRL_FIFO_LEVEL_EN macro.
package srl_fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Legal configuration: at least two words, all of them addressable.
  function automatic bit params_ok(input int depth, input int addr_width);
    return (depth >= 2) && (clog2(depth) <= addr_width);
  endfunction

endpackage

// File: rtl/srl_fifo_ctrl_if.sv
// Producer/consumer handshake bundle for srl_fifo_ctrl; the FIFO is the slave.
// Level outputs exist only when SRL_FIFO_LEVEL_EN is defined.
interface srl_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1
);
  logic                  if_write_ce;
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_full_n;
  logic                  if_read_ce;
  logic                  if_read;
  logic [DATA_WIDTH-1:0] if_dout;
  logic                  if_empty_n;
`ifdef SRL_FIFO_LEVEL_EN
  logic [ADDR_WIDTH:0]   if_num_data_valid;
  logic                  if_almost_full;
`endif

  modport master (
    output if_write_ce, if_write, if_din, if_read_ce, if_read,
`ifdef SRL_FIFO_LEVEL_EN
    input  if_num_data_valid, if_almost_full,
`endif
    input  if_full_n, if_dout, if_empty_n
  );

  modport slave (
    input  if_write_ce, if_write, if_din, if_read_ce, if_read,
`ifdef SRL_FIFO_LEVEL_EN
    output if_num_data_valid, if_almost_full,
`endif
    output if_full_n, if_dout, if_empty_n
  );
endinterface

// File: rtl/srl_fifo_ctrl_storage.sv
// Shift-register word array: a write shifts every word up one slot and loads
// slot 0; the read port is a plain combinational mux on addr.
module srl_fifo_storage #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; the controller's flags mark which slots hold valid data.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = DEPTH - 1; i > 0; i--) mem[i] <= mem[i-1];
      mem[0] <= din;
    end
  end

  assign dout = mem[addr];
endmodule

// File: rtl/srl_fifo_ctrl.sv
// SRL FIFO controller: occupancy tracking, storage write/address control and
// registered full_n/empty_n flags. SRL_FIFO_LEVEL_EN adds level outputs.
module srl_fifo_ctrl
  import srl_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input logic           clk,
  input logic           reset,
  srl_fifo_ctrl_if.slave fifo
);
  localparam int OW = ADDR_WIDTH + 1;
  localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);
  localparam logic [OW-1:0] OCC_AF   = OW'(DEPTH - 1);

  if (!params_ok(DEPTH, ADDR_WIDTH)) begin : g_bad_params
    $error("srl_fifo_ctrl: need DEPTH >= 2 and DEPTH <= 2**ADDR_WIDTH");
  end

  logic [OW-1:0]         occ_d, occ_q;
  logic                  empty_n_d, empty_n_q;
  logic                  full_n_d, full_n_q;
  logic                  push, pop;
  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    push  = fifo.if_write & fifo.if_write_ce & full_n_q;
    pop   = fifo.if_read & fifo.if_read_ce & empty_n_q;
    occ_d = occ_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;  // idle, or push+pop: shift in place
    endcase
    empty_n_d = (occ_d != '0);
    full_n_d  = (occ_d != OCC_FULL);
  end

  always_comb begin
    if (occ_q == '0)           state = EMPTY;
    else if (occ_q == OCC_FULL) state = FULL;
    else                       state = PARTIAL;
    // Head of queue is the oldest word, at slot occ-1 of the shift array.
    addr = (state == EMPTY) ? '0 : ADDR_WIDTH'(occ_q - 1'b1);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q     <= '0;
      empty_n_q <= 1'b0;
      full_n_q  <= 1'b1;
    end else begin
      occ_q     <= occ_d;
      empty_n_q <= empty_n_d;
      full_n_q  <= full_n_d;
    end
  end

  assign fifo.if_empty_n = empty_n_q;
  assign fifo.if_full_n  = full_n_q;

`ifdef SRL_FIFO_LEVEL_EN
  logic almost_full_d, almost_full_q;

  always_comb begin
    almost_full_d = (occ_d >= OCC_AF);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) almost_full_q <= 1'b0;
    else       almost_full_q <= almost_full_d;
  end

  assign fifo.if_num_data_valid = occ_q;
  assign fifo.if_almost_full    = almost_full_q;
`endif

  srl_fifo_storage #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_storage (
    .clk (clk),
    .we  (push),
    .addr(addr),
    .din (fifo.if_din),
    .dout(fifo.if_dout)
  );
endmodule
